// File: rtl/chan_burst_injector.sv
// rtl/chan_burst_injector.sv - LFSR-driven burst error injector for the encoder->decoder channel
// Optional macro CHAN_INJ_STATS_EN builds the saturating error statistics counters.
module chan_burst_injector #(
  parameter int          W      = 2,
  parameter int          RATE_W = 5,
  parameter int          BL_W   = 4,
  parameter logic [31:0] SEED   = 32'hACE1_2468
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [W-1:0]      sym_i,
  input  logic              en_i,
  input  logic [RATE_W-1:0] rate_i,
  input  logic [BL_W-1:0]   burst_len_i,
  input  logic              clr_i,
  output logic              valid_o,
  output logic [W-1:0]      sym_o,
  output logic [W-1:0]      clean_o,
  output logic [W-1:0]      err_mask_o,
  output logic [15:0]       err_bit_ct_o,
  output logic [15:0]       err_evt_ct_o
);

  localparam logic [31:0] TAPS    = 32'h8020_0003;
  localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state;
  logic [BL_W-1:0]   rem;
  logic [31:0]       lfsr;
  logic [W-1:0]      rnd_mask;
  logic [W-1:0]      mask;
  logic [BL_W-1:0]   bl;
  logic              start;
  logic              corrupt;

  // Random fields come from the pre-advance LFSR value; a zero mask would hide an event.
  always_comb begin
    rnd_mask = lfsr[16 +: W];
    if (rnd_mask == '0) rnd_mask[0] = 1'b1;
    start   = (state == IDLE) && valid_i && en_i && (lfsr[RATE_W-1:0] < rate_i);
    corrupt = start || ((state == BURST) && valid_i && en_i);
    mask    = corrupt ? rnd_mask : '0;
    bl      = (burst_len_i == '0) ? BL_W'(1) : burst_len_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rem        <= '0;
      lfsr       <= SEED_NZ;
      valid_o    <= 1'b0;
      sym_o      <= '0;
      clean_o    <= '0;
      err_mask_o <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        lfsr       <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);
        sym_o      <= sym_i ^ mask;
        clean_o    <= sym_i;
        err_mask_o <= mask;
      end
      case (state)
        IDLE: begin
          if (start && (bl != BL_W'(1))) begin
            rem   <= bl - BL_W'(1);
            state <= BURST;
          end
        end
        BURST: begin
          // Dropping enable abandons the burst even between symbols.
          if (!en_i) begin
            state <= IDLE;
            rem   <= '0;
          end else if (valid_i) begin
            if (rem == BL_W'(1)) begin
              state <= IDLE;
              rem   <= '0;
            end else begin
              rem <= rem - BL_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          rem   <= '0;
        end
      endcase
    end
  end

`ifdef CHAN_INJ_STATS_EN
  localparam int PC_W = $clog2(W + 1);

  logic [PC_W-1:0] pop;
  logic [16:0]     bit_sum;
  logic [16:0]     evt_sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) pop = pop + PC_W'(mask[i]);
    bit_sum = {1'b0, err_bit_ct_o} + 17'(pop);
    evt_sum = {1'b0, err_evt_ct_o} + 17'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_bit_ct_o <= '0;
      err_evt_ct_o <= '0;
    end else if (clr_i) begin
      err_bit_ct_o <= '0;
      err_evt_ct_o <= '0;
    end else begin
      if (corrupt) err_bit_ct_o <= bit_sum[16] ? 16'hFFFF : bit_sum[15:0];
      if (start)   err_evt_ct_o <= evt_sum[16] ? 16'hFFFF : evt_sum[15:0];
    end
  end
`else
  logic unused_clr;
  assign unused_clr   = clr_i;
  assign err_bit_ct_o = 16'h0;
  assign err_evt_ct_o = 16'h0;
`endif

endmodule

// File: tb/tb_chan_burst_injector.sv
// tb/tb_chan_burst_injector.sv - randomized scoreboard bench for chan_burst_injector
// Expected counters follow CHAN_INJ_STATS_EN the same way the design does.
module tb_chan_burst_injector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  sym_i = '0;
  logic        en_i = 1'b0;
  logic [4:0]  rate_i = '0;
  logic [3:0]  burst_len_i = '0;
  logic        clr_i = 1'b0;
  logic        valid_o;
  logic [1:0]  sym_o, clean_o, err_mask_o;
  logic [15:0] err_bit_ct_o, err_evt_ct_o;

  chan_burst_injector dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .en_i(en_i),
    .rate_i(rate_i), .burst_len_i(burst_len_i), .clr_i(clr_i),
    .valid_o(valid_o), .sym_o(sym_o), .clean_o(clean_o), .err_mask_o(err_mask_o),
    .err_bit_ct_o(err_bit_ct_o), .err_evt_ct_o(err_evt_ct_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sym;
    logic [1:0] clean;
    logic [1:0] mask;
    int         bits;
    int         evt;
  } exp_t;

  exp_t        q[$];
  int          nchk = 0, nerr = 0;
  int          n_in = 0, n_out = 0;
  logic [31:0] m_lfsr = 32'hACE1_2468;
  int          m_left = 0, m_bits = 0, m_evt = 0;
  logic [1:0]  last_sym = '0, last_clean = '0, last_mask = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int stat(input int v);
`ifdef CHAN_INJ_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [1:0] mask_field(input logic [31:0] l);
    logic [1:0] m;
    m = l[17:16];
    return (m == 2'b00) ? 2'b01 : m;
  endfunction

  // Reference: a burst is "how many more symbols to corrupt"; rate is a probability threshold.
  task automatic step(input logic v, input logic [1:0] s, input logic e,
                      input logic [4:0] r, input logic [3:0] b, input logic c);
    exp_t       x;
    logic [1:0] m;
    @(posedge clk); #1;
    valid_i = v; sym_i = s; en_i = e; rate_i = r; burst_len_i = b; clr_i = c;
    if (!e) m_left = 0;
    m = 2'b00;
    if (v) begin
      if (m_left > 0) begin
        m = mask_field(m_lfsr);
        m_left--;
      end else if (e && (int'(m_lfsr[4:0]) < int'(r))) begin
        m = mask_field(m_lfsr);
        m_evt = (m_evt < 65535) ? m_evt + 1 : 65535;
        m_left = ((b == 4'd0) ? 1 : int'(b)) - 1;
      end
      m_bits = m_bits + int'(m[0]) + int'(m[1]);
      if (m_bits > 65535) m_bits = 65535;
      m_lfsr = lfsr_next(m_lfsr);
    end
    if (c) begin
      m_bits = 0;
      m_evt  = 0;
    end
    if (v) begin
      x.sym = s ^ m; x.clean = s; x.mask = m; x.bits = m_bits; x.evt = m_evt;
      q.push_back(x);
      n_in++;
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      check("rst_valid_o", 32'(valid_o), 0);
      check("rst_sym_o", 32'(sym_o), 0);
      check("rst_clean_o", 32'(clean_o), 0);
      check("rst_mask_o", 32'(err_mask_o), 0);
      check("rst_bit_ct", 32'(err_bit_ct_o), 0);
      check("rst_evt_ct", 32'(err_evt_ct_o), 0);
      last_sym = '0; last_clean = '0; last_mask = '0;
    end else if (valid_o) begin
      n_out++;
      if (q.size() == 0) begin
        check("unexpected_valid_o", 32'(valid_o), 0);
      end else begin
        x = q.pop_front();
        check("sym_o", 32'(sym_o), 32'(x.sym));
        check("clean_o", 32'(clean_o), 32'(x.clean));
        check("err_mask_o", 32'(err_mask_o), 32'(x.mask));
        check("err_bit_ct_o", 32'(err_bit_ct_o), 32'(stat(x.bits)));
        check("err_evt_ct_o", 32'(err_evt_ct_o), 32'(stat(x.evt)));
        last_sym = x.sym; last_clean = x.clean; last_mask = x.mask;
      end
    end else begin
      check("hold_sym_o", 32'(sym_o), 32'(last_sym));
      check("hold_clean_o", 32'(clean_o), 32'(last_clean));
      check("hold_mask_o", 32'(err_mask_o), 32'(last_mask));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Zero rate: transparent channel, counters stay at zero.
    for (int i = 0; i < 1000; i++) step(1'b1, 2'($urandom), 1'b1, 5'd0, 4'($urandom), 1'b0);
    step(1'b0, 2'd0, 1'b1, 5'd0, 4'd3, 1'b0);
    check("rate0_bit_ct", 32'(err_bit_ct_o), 0);
    check("rate0_evt_ct", 32'(err_evt_ct_o), 0);

    // Near-certain starts, 3-symbol bursts, continuous valid.
    for (int i = 0; i < 300; i++) step(1'b1, 2'($urandom), 1'b1, 5'h1F, 4'd3, 1'b0);

    // Valid gaps of 4 cycles inside bursts.
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 2'($urandom), 1'b1, 5'h1F, 4'd3, 1'b0);
      repeat (4) step(1'b0, 2'($urandom), 1'b1, 5'h1F, 4'd3, 1'b0);
    end

    // Enable drop on the 2nd symbol of a 3-symbol burst.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 64 && m_left != 2; i++) step(1'b1, 2'($urandom), 1'b1, 5'h1F, 4'd3, 1'b0);
      check("burst_started", 32'(m_left), 2);
      step(1'b1, 2'($urandom), 1'b0, 5'h1F, 4'd3, 1'b0);
      repeat (3) step(1'b1, 2'($urandom), 1'b1, 5'd0, 4'd3, 1'b0);
    end

    // Fully random traffic including burst_len 0 and sporadic clears.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 7) != 0,
           5'($urandom), 4'($urandom), $urandom_range(0, 63) == 0);

    // Push the flipped-bit counter into saturation.
    for (int i = 0; i < 60000; i++) step(1'b1, 2'($urandom), 1'b1, 5'h1F, 4'd15, 1'b0);
    step(1'b0, 2'd0, 1'b1, 5'h1F, 4'd15, 1'b0);
    check("bit_ct_saturated", 32'(err_bit_ct_o), 32'(stat(65535)));

    // Clear coinciding with corrupted symbols.
    for (int i = 0; i < 4; i++) step(1'b1, 2'($urandom), 1'b1, 5'h1F, 4'd15, 1'b1);
    step(1'b0, 2'd0, 1'b1, 5'h1F, 4'd15, 1'b0);
    check("clr_bit_ct", 32'(err_bit_ct_o), 0);
    check("clr_evt_ct", 32'(err_evt_ct_o), 0);

    // Reset in the middle of a long burst.
    for (int i = 0; i < 64 && m_left < 5; i++) step(1'b1, 2'($urandom), 1'b1, 5'h1F, 4'd15, 1'b0);
    check("long_burst_active", 32'(m_left >= 5), 1);
    step(1'b0, 2'd0, 1'b1, 5'h1F, 4'd15, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    valid_i = 1'b0;
    m_lfsr = 32'hACE1_2468; m_left = 0; m_bits = 0; m_evt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step(1'b1, 2'b10, 1'b1, 5'h1F, 4'd1, 1'b0);
    step(1'b1, 2'b01, 1'b1, 5'd0, 4'd1, 1'b0);
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 1) == 1, 2'($urandom), 1'b1, 5'($urandom), 4'($urandom), 1'b0);

    repeat (3) step(1'b0, 2'd0, 1'b1, 5'd0, 4'd1, 1'b0);
    check("queue_drained", 32'(q.size()), 0);
    check("valid_count", 32'(n_out), 32'(n_in));
    check("final_bit_ct", 32'(err_bit_ct_o), 32'(stat(m_bits)));
    check("final_evt_ct", 32'(err_evt_ct_o), 32'(stat(m_evt)));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
